// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C command sequencer.
//  - state_t     : sequencer FSM state encoding
//  - Stat*       : bit positions inside STATUS
//  - n_byte_word : layout of the word written with I2C_LOAD_N_BYTE
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StLdnb,
    StLdad,
    StWrb,
    StExec,
    StRun,
    StDone
  } state_t;

  localparam int unsigned StatNack = 0;
  localparam int unsigned StatTmo  = 1;
  localparam int unsigned StatLen  = 2;

  // Largest byte count the interface buffer holds; also the read-back counter ceiling.
  localparam int unsigned LenMax = 15;

  // Byte-count word: {LEN[3:0], RD, 3'b000}
  function automatic logic [7:0] n_byte_word(input logic [3:0] len, input logic rd);
    return {len, rd, 3'b000};
  endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Bundle of requester-side and I2C-interface-side signals of the command sequencer.
//  master : sequencer view (drives GNT/WD_RD/RD_*/DONE/STATUS and all I2C_* controls)
//  slave  : environment view (requesters plus the I2C_intrf instances)
interface i2c_cmd_sequencer_if #(
  parameter int unsigned N_DEV = 4,
  parameter int unsigned DEVW  = 2
);
  // Requester side, bit/byte slices ordered [R1, R0]
  logic [1:0]        REQ;
  logic [2*DEVW-1:0] REQ_DEV;
  logic [1:0]        REQ_RD;
  logic [7:0]        REQ_LEN;
  logic [15:0]       REQ_ADDR;
  logic [1:0]        GNT;
  logic [15:0]       WD_DATA;
  logic [1:0]        WD_RD;
  logic [7:0]        RD_DATA;
  logic [1:0]        RD_VLD;
  logic [1:0]        DONE;
  logic [2:0]        STATUS;
  // I2C_intrf side
  logic [N_DEV-1:0]  I2C_DEV_SEL;
  logic              I2C_LOAD_N_BYTE;
  logic              I2C_LOAD_ADDR;
  logic [3:0]        I2C_WRT_ADDR;
  logic [7:0]        I2C_WRT_DATA;
  logic              I2C_WRT_ENA;
  logic              I2C_EXECUTE;
  logic              I2C_READY;
  logic              I2C_RBK_WE;
  logic [7:0]        I2C_RBK_DATA;
  logic              I2C_S_NACK;

  modport master (
    input  REQ, REQ_DEV, REQ_RD, REQ_LEN, REQ_ADDR, WD_DATA,
    input  I2C_READY, I2C_RBK_WE, I2C_RBK_DATA, I2C_S_NACK,
    output GNT, WD_RD, RD_DATA, RD_VLD, DONE, STATUS,
    output I2C_DEV_SEL, I2C_LOAD_N_BYTE, I2C_LOAD_ADDR, I2C_WRT_ADDR, I2C_WRT_DATA,
    output I2C_WRT_ENA, I2C_EXECUTE
  );

  modport slave (
    output REQ, REQ_DEV, REQ_RD, REQ_LEN, REQ_ADDR, WD_DATA,
    output I2C_READY, I2C_RBK_WE, I2C_RBK_DATA, I2C_S_NACK,
    input  GNT, WD_RD, RD_DATA, RD_VLD, DONE, STATUS,
    input  I2C_DEV_SEL, I2C_LOAD_N_BYTE, I2C_LOAD_ADDR, I2C_WRT_ADDR, I2C_WRT_DATA,
    input  I2C_WRT_ENA, I2C_EXECUTE
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal, resets to 0.
//  clk_i  : destination clock
//  rst_ni : asynchronous active-low reset
//  d_i    : asynchronous input level
//  q_o    : synchronized level
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Shares a bank of I2C_intrf instances between two requesters (R0 slow-control, R1 power-up
// init). Per granted request it selects the device, loads byte count and register address,
// fills the write buffer, fires EXECUTE, waits for completion with a timeout, forwards
// read-back bytes and reports STATUS with DONE. Round-robin arbitration.
//  CLK40, RST_N : 40 MHz clock, asynchronous active-low reset
//  bus          : requester handshake and I2C interface controls (master modport)
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned N_DEV   = 4,
  parameter int unsigned DEVW    = 2,
  parameter int unsigned TMO_CYC = 40000
) (
  input logic                 CLK40,
  input logic                 RST_N,
  i2c_cmd_sequencer_if.master bus
);

  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);

  logic rdy_s, nack_s;

  sync_2ff u_sync_rdy  (.clk_i(CLK40), .rst_ni(RST_N), .d_i(bus.I2C_READY),  .q_o(rdy_s));
  sync_2ff u_sync_nack (.clk_i(CLK40), .rst_ni(RST_N), .d_i(bus.I2C_S_NACK), .q_o(nack_s));

  state_t          state_q, state_d;
  logic            last_q, last_d;       // requester served most recently
  logic            req_q, req_d;         // requester owning the current transaction
  logic [DEVW-1:0] dev_q, dev_d;
  logic            rd_q, rd_d;
  logic [3:0]      len_q, len_d;
  logic [7:0]      addr_q, addr_d;
  logic            lerr_q, lerr_d;       // rejected descriptor: no bus activity at all
  logic [3:0]      wcnt_q, wcnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit_q, tmo_hit_d;
  logic [3:0]      rbk_cnt_q, rbk_cnt_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [1:0]      rd_vld_q, rd_vld_d;

  logic             pick;
  logic [DEVW-1:0]  pick_dev;
  logic [3:0]       pick_len;
  logic             tmo_exp;
  logic [N_DEV-1:0] dev_onehot;

  // Both requesting: serve the one not served last.
  assign pick     = (bus.REQ == 2'b11) ? ~last_q : bus.REQ[1];
  assign pick_dev = pick ? bus.REQ_DEV[2*DEVW-1:DEVW] : bus.REQ_DEV[DEVW-1:0];
  assign pick_len = pick ? bus.REQ_LEN[7:4] : bus.REQ_LEN[3:0];
  assign tmo_exp  = 32'(tmo_q) >= TMO_CYC;

  always_comb begin
    dev_onehot        = '0;
    dev_onehot[dev_q] = 1'b1;
  end

  assign bus.RD_DATA = rd_data_q;
  assign bus.RD_VLD  = rd_vld_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    req_d     = req_q;
    dev_d     = dev_q;
    rd_d      = rd_q;
    len_d     = len_q;
    addr_d    = addr_q;
    lerr_d    = lerr_q;
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
    tmo_hit_d = tmo_hit_q;
    rbk_cnt_d = rbk_cnt_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = '0;

    bus.GNT             = '0;
    bus.WD_RD           = '0;
    bus.DONE            = '0;
    bus.STATUS          = '0;
    bus.I2C_DEV_SEL     = '0;
    bus.I2C_LOAD_N_BYTE = 1'b0;
    bus.I2C_LOAD_ADDR   = 1'b0;
    bus.I2C_WRT_ADDR    = '0;
    bus.I2C_WRT_DATA    = '0;
    bus.I2C_WRT_ENA     = 1'b0;
    bus.I2C_EXECUTE     = 1'b0;

    if (state_q inside {StLdnb, StLdad, StWrb, StExec, StRun, StDone} && !lerr_q) begin
      bus.I2C_DEV_SEL = dev_onehot;
    end

    unique case (state_q)
      StIdle: begin
        // Interface busy (READY low) holds off any grant.
        if (|bus.REQ && rdy_s) state_d = StArb;
      end
      StArb: begin
        if (|bus.REQ) begin
          bus.GNT[pick] = 1'b1;
          req_d     = pick;
          last_d    = pick;
          dev_d     = pick_dev;
          rd_d      = bus.REQ_RD[pick];
          len_d     = pick_len;
          addr_d    = pick ? bus.REQ_ADDR[15:8] : bus.REQ_ADDR[7:0];
          wcnt_d    = '0;
          rbk_cnt_d = '0;
          tmo_hit_d = 1'b0;
          lerr_d    = (pick_len == 4'd0) || (32'(pick_dev) >= N_DEV);
          state_d   = lerr_d ? StDone : StLdnb;
        end else begin
          state_d = StIdle;
        end
      end
      StLdnb: begin
        bus.I2C_LOAD_N_BYTE = 1'b1;
        bus.I2C_WRT_DATA    = n_byte_word(len_q, rd_q);
        state_d             = StLdad;
      end
      StLdad: begin
        bus.I2C_LOAD_ADDR = 1'b1;
        bus.I2C_WRT_DATA  = addr_q;
        tmo_d             = '0;
        state_d           = rd_q ? StExec : StWrb;
      end
      StWrb: begin
        bus.WD_RD[req_q] = 1'b1;
        bus.I2C_WRT_ENA  = 1'b1;
        bus.I2C_WRT_ADDR = wcnt_q;
        bus.I2C_WRT_DATA = req_q ? bus.WD_DATA[15:8] : bus.WD_DATA[7:0];
        wcnt_d           = wcnt_q + 4'd1;
        if (wcnt_q == len_q - 4'd1) state_d = StExec;
      end
      StExec: begin
        tmo_d = tmo_q + TmoW'(1);
        if (tmo_exp) begin
          tmo_hit_d = 1'b1;
          state_d   = StDone;
        end else begin
          bus.I2C_EXECUTE = 1'b1;
          if (!rdy_s) state_d = StRun;
        end
      end
      StRun: begin
        tmo_d = tmo_q + TmoW'(1);
        if (rd_q && bus.I2C_RBK_WE) begin
          rd_data_d       = bus.I2C_RBK_DATA;
          rd_vld_d[req_q] = 1'b1;
          if (rbk_cnt_q != 4'(LenMax)) rbk_cnt_d = rbk_cnt_q + 4'd1;
        end
        if (tmo_exp) begin
          tmo_hit_d = 1'b1;
          state_d   = StDone;
        end else if (rdy_s) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bus.DONE[req_q] = 1'b1;
        if (lerr_q) begin
          bus.STATUS[StatLen] = 1'b1;
        end else begin
          bus.STATUS[StatNack] = nack_s;
          bus.STATUS[StatTmo]  = tmo_hit_q;
          bus.STATUS[StatLen]  = rd_q && (rbk_cnt_q != len_q);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;  // R1 "served last" so R0 wins the first tie
      req_q     <= 1'b0;
      dev_q     <= '0;
      rd_q      <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      lerr_q    <= 1'b0;
      wcnt_q    <= '0;
      tmo_q     <= '0;
      tmo_hit_q <= 1'b0;
      rbk_cnt_q <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      req_q     <= req_d;
      dev_q     <= dev_d;
      rd_q      <= rd_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      lerr_q    <= lerr_d;
      wcnt_q    <= wcnt_d;
      tmo_q     <= tmo_d;
      tmo_hit_q <= tmo_hit_d;
      rbk_cnt_q <= rbk_cnt_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: expected events are queued when a request is set up and
// compared when the DUT produces them; a behavioural I2C_intrf model answers EXECUTE.
module tb_i2c_cmd_sequencer;

  localparam int unsigned Tmo = 200;

  logic CLK40;
  logic RST_N;

  i2c_cmd_sequencer_if #(.N_DEV(4), .DEVW(2)) bus ();

  i2c_cmd_sequencer #(.N_DEV(4), .DEVW(2), .TMO_CYC(Tmo)) dut (
    .CLK40 (CLK40),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK40 = 1'b0;
    forever #5 CLK40 = ~CLK40;
  end

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard queues
  logic [1:0]  exp_gnt[$];   // one-hot grant
  logic [12:0] exp_load[$];  // {DEV_SEL, is_addr, WRT_DATA}
  logic [13:0] exp_wr[$];    // {WD_RD, WRT_ADDR, WRT_DATA}
  logic [9:0]  exp_rd[$];    // {RD_VLD, RD_DATA}
  logic [8:0]  exp_done[$];  // {DEV_SEL, DONE, STATUS}

  logic [7:0] wd_fifo0[$], wd_fifo1[$];
  logic [7:0] model_rbk[$];
  logic [7:0] wr_bytes[$], rd_bytes[$];
  bit model_hang = 1'b0;
  bit model_nack = 1'b0;
  int n_strobe = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.GNT, bus.WD_RD, bus.RD_VLD, bus.DONE, bus.STATUS, bus.I2C_DEV_SEL,
                bus.I2C_LOAD_N_BYTE, bus.I2C_LOAD_ADDR, bus.I2C_WRT_ADDR, bus.I2C_WRT_DATA,
                bus.I2C_WRT_ENA, bus.I2C_EXECUTE, bus.RD_DATA});
  endfunction

  // Queue everything one transaction should produce and present its descriptor.
  task automatic expect_txn(input int r, input int dev, input bit rd, input int len,
                            input logic [7:0] addr, input logic [2:0] status, input bit with_done);
    logic [3:0] sel;
    logic [3:0] l4;
    l4  = 4'(len);
    sel = (len == 0) ? 4'b0000 : 4'(1 << dev);
    exp_gnt.push_back(2'(1 << r));
    if (len != 0) begin
      exp_load.push_back({sel, 1'b0, l4, rd, 3'b000});
      exp_load.push_back({sel, 1'b1, addr});
    end
    foreach (wr_bytes[k]) begin
      exp_wr.push_back({2'(1 << r), 4'(k), wr_bytes[k]});
      if (r == 0) wd_fifo0.push_back(wr_bytes[k]);
      else        wd_fifo1.push_back(wr_bytes[k]);
    end
    foreach (rd_bytes[k]) begin
      exp_rd.push_back({2'(1 << r), rd_bytes[k]});
      model_rbk.push_back(rd_bytes[k]);
    end
    if (with_done) exp_done.push_back({sel, 2'(1 << r), status});
    bus.REQ_DEV[r*2 +: 2]  = 2'(dev);
    bus.REQ_RD[r]          = rd;
    bus.REQ_LEN[r*4 +: 4]  = l4;
    bus.REQ_ADDR[r*8 +: 8] = addr;
    wr_bytes.delete();
    rd_bytes.delete();
  endtask

  // Drop each requester's REQ on its DONE; bounded.
  task automatic wait_dones(input logic [1:0] mask, input int budget);
    logic [1:0] pend;
    int n;
    pend = mask;
    n = 0;
    while (pend != 2'b00 && n < budget) begin
      @(negedge CLK40);
      n++;
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && bus.DONE[i]) begin
          pend[i]    = 1'b0;
          bus.REQ[i] = 1'b0;
        end
      end
    end
    check("done_arrived", 64'(pend), 64'd0);
  endtask

  // Scoreboard monitor and write-data FIFO (first-word-fall-through).
  initial begin
    bus.WD_DATA = '0;
    forever begin
      @(negedge CLK40);
      if (bus.I2C_LOAD_N_BYTE || bus.I2C_LOAD_ADDR || bus.I2C_WRT_ENA || bus.I2C_EXECUTE)
        n_strobe++;
      if (|bus.GNT) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(bus.GNT), 64'd0);
        else check("gnt_order", 64'(bus.GNT), 64'(exp_gnt.pop_front()));
      end
      if (bus.I2C_LOAD_N_BYTE || bus.I2C_LOAD_ADDR) begin
        if (exp_load.size() == 0) check("load_unexpected", 64'(bus.I2C_WRT_DATA), 64'd0);
        else check("load_word", 64'({bus.I2C_DEV_SEL, bus.I2C_LOAD_ADDR, bus.I2C_WRT_DATA}),
                   64'(exp_load.pop_front()));
      end
      if (bus.I2C_WRT_ENA || |bus.WD_RD) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 64'(bus.WD_RD), 64'd0);
        else check("wr_byte", 64'({bus.WD_RD, bus.I2C_WRT_ADDR, bus.I2C_WRT_DATA}),
                   64'(exp_wr.pop_front()));
      end
      if (|bus.RD_VLD) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 64'(bus.RD_VLD), 64'd0);
        else check("rd_byte", 64'({bus.RD_VLD, bus.RD_DATA}), 64'(exp_rd.pop_front()));
      end
      if (|bus.DONE) begin
        if (exp_done.size() == 0) check("done_unexpected", 64'(bus.DONE), 64'd0);
        else check("done_status", 64'({bus.I2C_DEV_SEL, bus.DONE, bus.STATUS}),
                   64'(exp_done.pop_front()));
      end
      if (bus.WD_RD[0] && wd_fifo0.size() != 0) void'(wd_fifo0.pop_front());
      if (bus.WD_RD[1] && wd_fifo1.size() != 0) void'(wd_fifo1.pop_front());
      bus.WD_DATA = {(wd_fifo1.size() != 0) ? wd_fifo1[0] : 8'h00,
                     (wd_fifo0.size() != 0) ? wd_fifo0[0] : 8'h00};
    end
  end

  // I2C_intrf model: READY drops a few cycles after EXECUTE, read bytes strobed, READY returns.
  initial begin
    bus.I2C_READY    = 1'b1;
    bus.I2C_RBK_WE   = 1'b0;
    bus.I2C_RBK_DATA = '0;
    bus.I2C_S_NACK   = 1'b0;
    forever begin
      @(negedge CLK40);
      if (bus.I2C_EXECUTE === 1'b1) begin
        repeat (3) @(negedge CLK40);
        bus.I2C_READY  = 1'b0;
        bus.I2C_S_NACK = model_nack;
        wait (model_hang == 1'b0);
        repeat (4) @(negedge CLK40);
        while (model_rbk.size() != 0) begin
          bus.I2C_RBK_DATA = model_rbk.pop_front();
          bus.I2C_RBK_WE   = 1'b1;
          @(negedge CLK40);
          bus.I2C_RBK_WE = 1'b0;
          repeat (2) @(negedge CLK40);
        end
        bus.I2C_READY = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int snap;
    bus.REQ      = '0;
    bus.REQ_DEV  = '0;
    bus.REQ_RD   = '0;
    bus.REQ_LEN  = '0;
    bus.REQ_ADDR = '0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK40);
    check("reset_outputs", all_outs(), 64'd0);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK40);

    // R0 write dev1 addr 0x10, 3 bytes
    wr_bytes = '{8'hA5, 8'h5A, 8'hC3};
    expect_txn(0, 1, 1'b0, 3, 8'h10, 3'b000, 1'b1);
    bus.REQ[0] = 1'b1;
    wait_dones(2'b01, 200);

    // R1 read dev0 LEN=2
    rd_bytes = '{8'h11, 8'h22};
    expect_txn(1, 0, 1'b1, 2, 8'h20, 3'b000, 1'b1);
    bus.REQ[1] = 1'b1;
    wait_dones(2'b10, 200);

    // Simultaneous requests, two rounds: R0 then R1 each time
    for (int round = 0; round < 2; round++) begin
      wr_bytes = '{8'(8'hB1 + round)};
      expect_txn(0, 2, 1'b0, 1, 8'(8'h31 + round), 3'b000, 1'b1);
      wr_bytes = '{8'(8'hC1 + round), 8'(8'hD1 + round)};
      expect_txn(1, 3, 1'b0, 2, 8'(8'h41 + round), 3'b000, 1'b1);
      bus.REQ = 2'b11;
      wait_dones(2'b11, 400);
    end

    // Timeout: READY held low after EXECUTE
    model_hang = 1'b1;
    wr_bytes = '{8'h77};
    expect_txn(0, 2, 1'b0, 1, 8'h50, 3'b010, 1'b1);
    bus.REQ[0] = 1'b1;
    n = 0;
    while (bus.I2C_EXECUTE !== 1'b1 && n < 50) begin
      @(negedge CLK40);
      n++;
    end
    n = 0;
    while (bus.DONE[0] !== 1'b1 && n < int'(Tmo) + 20) begin
      @(negedge CLK40);
      n++;
    end
    bus.REQ[0] = 1'b0;
    check("tmo_latency_in_range", 64'(n >= int'(Tmo) && n <= int'(Tmo) + 2), 64'd1);
    check("tmo_execute_low", 64'(bus.I2C_EXECUTE), 64'd0);
    model_hang = 1'b0;
    repeat (10) @(negedge CLK40);

    // NACK with short read: 1 of 4 bytes
    model_nack = 1'b1;
    rd_bytes = '{8'h99};
    expect_txn(1, 3, 1'b1, 4, 8'h5E, 3'b101, 1'b1);
    bus.REQ[1] = 1'b1;
    wait_dones(2'b10, 200);
    model_nack = 1'b0;

    // LEN=0: grant then length-error DONE, no bus activity
    snap = n_strobe;
    expect_txn(0, 0, 1'b0, 0, 8'h60, 3'b100, 1'b1);
    bus.REQ[0] = 1'b1;
    wait_dones(2'b01, 50);
    repeat (3) @(negedge CLK40);
    check("len0_no_bus_activity", 64'(n_strobe - snap), 64'd0);

    // Reset while in RUN: everything drops, no DONE
    model_hang = 1'b1;
    wr_bytes = '{8'h3C};
    expect_txn(1, 1, 1'b0, 1, 8'h70, 3'b000, 1'b0);
    bus.REQ[1] = 1'b1;
    n = 0;
    while (bus.I2C_EXECUTE !== 1'b1 && n < 50) begin
      @(negedge CLK40);
      n++;
    end
    n = 0;
    while (bus.I2C_EXECUTE !== 1'b0 && n < 50) begin
      @(negedge CLK40);
      n++;
    end
    repeat (3) @(negedge CLK40);
    check("run_dev_sel_held", 64'(bus.I2C_DEV_SEL), 64'h2);
    RST_N = 1'b0;
    #1;
    check("midrun_reset_outputs", all_outs(), 64'd0);
    bus.REQ[1] = 1'b0;
    repeat (2) @(negedge CLK40);
    RST_N = 1'b1;
    model_hang = 1'b0;
    repeat (30) @(negedge CLK40);

    // Recovery after reset
    rd_bytes = '{8'h5B};
    expect_txn(0, 2, 1'b1, 1, 8'h44, 3'b000, 1'b1);
    bus.REQ[0] = 1'b1;
    wait_dones(2'b01, 200);
    repeat (5) @(negedge CLK40);

    check("scoreboard_drained",
          64'(exp_gnt.size() + exp_load.size() + exp_wr.size() + exp_rd.size() + exp_done.size()),
          64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
